// File: rtl/unary_pkg.sv
// Shared types and constants for the unary serial encoder.
// Holds the FSM state enum, the code-mode selectors and the compare-width helper.
package unary_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int MODE_THERM  = 0;
  localparam int MODE_ONEHOT = 1;

  // Width that holds both the full input value and any code index without truncation.
  function automatic int cmp_width(input int din, input int len);
    return (din > $clog2(len) + 1) ? din : $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/unary_chunk.sv
// Combinational slice of a thermometer/one-hot code: produces the W code bits of beat k.
// Values at or beyond LEN clamp naturally because no code index ever reaches them.
module unary_chunk
  import unary_pkg::*;
#(
  parameter int DIN  = 6,
  parameter int LEN  = 32,
  parameter int W    = 8,
  parameter int KW   = 2,
  parameter int MODE = MODE_THERM
) (
  input  logic [DIN-1:0] val,
  input  logic [KW-1:0]  k,
  output logic [W-1:0]   chunk
);

  localparam int CW = cmp_width(DIN, LEN);

  logic [CW-1:0] val_ext;
  logic [CW-1:0] base;

  always_comb begin
    val_ext = CW'(val);
    base    = CW'(k) * CW'(W);
    chunk   = '0;
    for (int i = 0; i < W; i++) begin
      if (MODE == MODE_ONEHOT) chunk[i] = ((base + CW'(i)) == val_ext);
      else                     chunk[i] = ((base + CW'(i)) <  val_ext);
    end
  end

endmodule

// File: rtl/unary_serial.sv
// Unary (thermometer / one-hot) serializer: accepts a value, emits LEN code bits
// as LEN/W beats of W bits, with a last-beat flag in the top bit of dout_data.
//
// state | meaning
// IDLE  | no value held, ready for input
// EMIT  | value held, beats k..NB-1 pending
module unary_serial
  import unary_pkg::*;
#(
  parameter int DIN  = 6,
  parameter int LEN  = 32,
  parameter int W    = 8,
  parameter int MODE = MODE_THERM
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic [DIN-1:0] din_data,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [W:0]     dout_data
);

  localparam int NB = LEN / W;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  state_t         state, state_nxt;
  logic [DIN-1:0] val, val_nxt;
  logic [KW-1:0]  k, k_nxt;
  logic           last;
  logic [W-1:0]   chunk;

  unary_chunk #(
    .DIN  (DIN),
    .LEN  (LEN),
    .W    (W),
    .KW   (KW),
    .MODE (MODE)
  ) u_chunk (
    .val   (val),
    .k     (k),
    .chunk (chunk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      val   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      val   <= val_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    val_nxt    = val;
    k_nxt      = k;
    last       = (k == K_LAST);
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_data  = '0;
    unique case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          val_nxt   = din_data;
          k_nxt     = '0;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        dout_valid = 1'b1;
        dout_data  = {last, chunk};
        // Accept the next value only as the final beat leaves, so streams have no bubbles.
        din_ready  = dout_ready && last;
        if (dout_ready) begin
          if (!last) begin
            k_nxt = k + KW'(1);
          end else if (din_valid) begin
            val_nxt = din_data;
            k_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unary_serial.sv
// Directed bench for unary_serial: thermometer and one-hot instances share stimulus,
// plus a single-beat (W=LEN) instance.
module tb_unary_serial;

  logic clk = 1'b0;
  logic rst;

  logic       din_valid, dout_ready;
  logic [5:0] din_data;
  logic       din_ready0, dout_valid0, din_ready1, dout_valid1;
  logic [8:0] dout_data0, dout_data1;

  logic        din_valid2, dout_ready2, din_ready2, dout_valid2;
  logic [5:0]  din_data2;
  logic [32:0] dout_data2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unary_serial #(.DIN(6), .LEN(32), .W(8), .MODE(0)) u_therm (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready0),
    .din_data(din_data), .dout_valid(dout_valid0), .dout_ready(dout_ready),
    .dout_data(dout_data0)
  );

  unary_serial #(.DIN(6), .LEN(32), .W(8), .MODE(1)) u_onehot (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready1),
    .din_data(din_data), .dout_valid(dout_valid1), .dout_ready(dout_ready),
    .dout_data(dout_data1)
  );

  unary_serial #(.DIN(6), .LEN(32), .W(32), .MODE(0)) u_wide (
    .clk(clk), .rst(rst), .din_valid(din_valid2), .din_ready(din_ready2),
    .din_data(din_data2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .dout_data(dout_data2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tg, input int b, input logic [31:0] c0,
                          input logic [31:0] c1);
    chk($sformatf("%s_v0_b%0d", tg, b), dout_valid0, 1);
    chk($sformatf("%s_v1_b%0d", tg, b), dout_valid1, 1);
    chk($sformatf("%s_d0_b%0d", tg, b), dout_data0, {b == 3, c0[b*8 +: 8]});
    chk($sformatf("%s_d1_b%0d", tg, b), dout_data1, {b == 3, c1[b*8 +: 8]});
  endtask

  // One value through both 4-beat instances with dout_ready held high.
  task automatic run_value(input logic [5:0] v, input logic [31:0] c0,
                           input logic [31:0] c1, input string tg);
    @(negedge clk);
    chk({tg, "_idle_rdy"}, din_ready0, 1);
    chk({tg, "_idle_vld"}, dout_valid0, 0);
    din_valid  = 1'b1;
    din_data   = v;
    dout_ready = 1'b1;
    #1;
    chk({tg, "_same_cycle_vld"}, dout_valid0, 0);
    @(negedge clk);
    din_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk_beat(tg, b, c0, c1);
      @(negedge clk);
    end
    chk({tg, "_done_vld"}, dout_valid0, 0);
    chk({tg, "_done_data"}, dout_data0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int beat;
    int budget;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [5:0] vals [3];
    logic [31:0] e0 [3];
    logic [31:0] e1 [3];

    rst = 1'b1;
    din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
    din_valid2 = 1'b0; din_data2 = '0; dout_ready2 = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_vld0", dout_valid0, 0);
    chk("rst_rdy0", din_ready0, 1);
    chk("rst_data0", dout_data0, 0);
    chk("rst_data1", dout_data1, 0);
    chk("rst_vld2", dout_valid2, 0);
    chk("rst_data2", dout_data2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_data1", dout_data1, 0);

    run_value(6'd11, 32'h0000_07FF, 32'h0000_0800, "v11");
    run_value(6'd9,  32'h0000_01FF, 32'h0000_0200, "v9");
    run_value(6'd40, 32'hFFFF_FFFF, 32'h0000_0000, "v40");
    run_value(6'd32, 32'hFFFF_FFFF, 32'h0000_0000, "v32");
    run_value(6'd31, 32'h7FFF_FFFF, 32'h8000_0000, "v31");

    // Back-to-back stream 3, 5, 0
    vals[0] = 6'd3;  e0[0] = 32'h0000_0007; e1[0] = 32'h0000_0008;
    vals[1] = 6'd5;  e0[1] = 32'h0000_001F; e1[1] = 32'h0000_0020;
    vals[2] = 6'd0;  e0[2] = 32'h0000_0000; e1[2] = 32'h0000_0001;
    @(negedge clk);
    din_valid = 1'b1; din_data = vals[0]; dout_ready = 1'b1;
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      chk_beat($sformatf("strm%0d", b / 4), b % 4, e0[b/4], e1[b/4]);
      chk($sformatf("strm_rdy_%0d", b), din_ready0, (b % 4) == 3);
      if ((b % 4) == 3 && (b / 4) < 2) begin
        din_valid = 1'b1;
        din_data  = vals[b/4 + 1];
      end else begin
        din_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("strm_end_vld", dout_valid0, 0);

    // Random stalls on din=20
    c0 = 32'h000F_FFFF; c1 = 32'h0010_0000;
    din_valid = 1'b1; din_data = 6'd20; dout_ready = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    beat = 0; budget = 0;
    while (beat < 4 && budget < 200) begin
      @(negedge clk);
      budget++;
      chk_beat("stall", beat, c0, c1);
      dout_ready = 1'($urandom_range(0, 1));
      if (dout_ready) beat++;
    end
    chk("stall_budget", budget < 200, 1);
    @(negedge clk);
    dout_ready = 1'b1;
    chk("stall_end_vld", dout_valid0, 0);

    // Reset in the middle of din=30
    c0 = 32'h3FFF_FFFF; c1 = 32'h4000_0000;
    @(negedge clk);
    din_valid = 1'b1; din_data = 6'd30;
    @(negedge clk);
    din_valid = 1'b0;
    chk_beat("r30", 0, c0, c1);
    @(negedge clk);
    chk_beat("r30", 1, c0, c1);
    rst = 1'b1;
    @(negedge clk);
    chk("r30_vld", dout_valid0, 0);
    chk("r30_vld1", dout_valid1, 0);
    chk("r30_data", dout_data0, 0);
    chk("r30_rdy", din_ready0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("r30_after_vld", dout_valid0, 0);
    run_value(6'd1, 32'h0000_0001, 32'h0000_0002, "v1");

    // Single-beat instance, din=31
    @(negedge clk);
    chk("w_idle_rdy", din_ready2, 1);
    din_valid2 = 1'b1; din_data2 = 6'd31;
    @(negedge clk);
    din_valid2 = 1'b0;
    chk("w_vld", dout_valid2, 1);
    chk("w_data", dout_data2, 33'h1_7FFF_FFFF);
    chk("w_rdy", din_ready2, 1);
    @(negedge clk);
    chk("w_end_vld", dout_valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unary_serial.md
UNARY_SERIAL -- requirements
Module: unary_serial

Interface
REQ-001 Parameter DIN, default 6: din_data width in bits, unsigned.
REQ-002 Parameter LEN, default 32: total code length in bits; LEN SHALL be a multiple of W.
REQ-003 Parameter W, default 8: code bits per output beat; number of beats NB = LEN/W.
REQ-004 Parameter MODE, default 0: 0 = thermometer code, 1 = one-hot code.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 din_valid  input  1  input value offered.
REQ-008 din_ready  output  1  input value accepted when din_valid and din_ready are both high.
REQ-009 din_data  input  DIN  unsigned value to encode.
REQ-010 dout_valid  output  1  output beat offered.
REQ-011 dout_ready  input  1  output beat consumed when dout_valid and dout_ready are both high.
REQ-012 dout_data  output  W+1  bits [W-1:0] = code chunk, bit [W] = last-beat flag.

Function
REQ-013 FSM states: IDLE (no value held) and EMIT (value held, beats pending).
REQ-014 IDLE: din_ready=1, dout_valid=0; din handshake latches din_data into val, clears beat counter k to 0, moves to EMIT.
REQ-015 EMIT: dout_valid=1; dout_data is a combinational function of val, k, MODE only.
REQ-016 Latency: first beat valid on the cycle after the din handshake; never on the same cycle.
REQ-017 Beat k, bit i (code index j = k*W+i): MODE 0 -> bit = (j < val); MODE 1 -> bit = (j == val).
REQ-018 Comparisons are unsigned, at least max(DIN, clog2(LEN)+1) bits wide; no truncation of val.
REQ-019 Clamping: val >= LEN gives all-ones code in MODE 0 and all-zeros code in MODE 1.
REQ-020 dout_data[W] = 1 exactly when k = NB-1.
REQ-021 dout handshake with k < NB-1: k increments by 1, state stays EMIT.
REQ-022 dout handshake with k = NB-1: beat completes; without a simultaneous din handshake, state goes to IDLE.
REQ-023 Back-to-back: in EMIT, din_ready = dout_ready and (k = NB-1); a simultaneous final dout handshake and din handshake latches the new value, sets k=0, and stays in EMIT, so there are no bubbles.
REQ-024 In EMIT, while dout_ready=0, dout_data and dout_valid SHALL hold stable.
REQ-025 din_ready SHALL NOT depend on din_valid; dout_valid SHALL NOT depend on dout_ready.
REQ-026 NB=1 (W=LEN) is legal: each value produces one beat with the last-beat flag set.

Reset
REQ-027 rst=1 forces state IDLE, k=0, val=0 on the next edge, overriding any handshake in that cycle.
REQ-028 During and after reset: dout_valid=0, din_ready=1 (IDLE), dout_data=0.
REQ-029 Reset mid-EMIT abandons remaining beats; no further beats of that value are emitted.

Structure
REQ-030 Shared package unary_pkg SHALL hold the state enum (IDLE, EMIT) and the MODE constants (MODE_THERM=0, MODE_ONEHOT=1).
REQ-031 Sub-module unary_chunk (combinational: val, k, MODE -> W-bit chunk) SHALL implement REQ-017 to REQ-019.
REQ-032 Top level holds only the FSM, val register, k counter (width clog2(NB), minimum 1) and handshake logic.

Verification
REQ-033 Defaults, MODE 0, din=11, dout_ready=1 -> 4 beats: 0xFF, 0x07, 0x00, 0x00; last flag only on the 4th beat; first beat one cycle after input.
REQ-034 MODE 1, din=9 -> beats 0x00, 0x02, 0x00, 0x00; din=40 (>=LEN) -> four 0x00 beats. MODE 0, din=40 -> four 0xFF beats.
REQ-035 Stream din=3, 5, 0 with dout_ready=1 -> 12 consecutive valid beats, no idle cycles; din_ready high only on each value's 4th beat.
REQ-036 Random dout_ready stalls (50%) on din=20 -> dout_data stable while stalled; delivered beats 0xFF, 0xFF, 0x0F, 0x00.
REQ-037 Assert rst after the 2nd beat of din=30 -> dout_valid=0 next cycle; din=1 then yields 0x01, 0x00, 0x00, 0x00.
REQ-038 W=32, LEN=32, din=31, MODE 0 -> single beat 0x7FFFFFFF with the last flag set.
